layer_controller: RTL and testbench

//  Parametrised successor of the single-neuron sequencing FSM. It drives one

---
 rtl/nn_ctrl_pkg.sv | 26 ++
 rtl/lat_timer.sv | 27 ++
 rtl/layer_controller.sv | 134 +++++++++++++
 tb/tb_layer_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neuron-layer sequencing controller: state encodings,
// latency counter width and the width helper used to size the neuron index.
package nn_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_ACC  = ST_ACC,
        S_OUT  = ST_OUT
    } state_e;

    localparam int unsigned LAT_W = 4;

    // ceil(log2(n)) but never below 1, so a single-neuron layer still has an index bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lat_timer.sv
// Loadable 4-bit down-counter with a zero flag; times the multiplier wait.
module lat_timer
    import nn_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/layer_controller.sv
// Sequences one neuron datapath over N_NEURONS neurons per start, with a result
// handshake per neuron. Optional CTRL_ABORT_EN adds an abort input.
module layer_controller
    import nn_ctrl_pkg::*;
#(
    parameter  int unsigned N_NEURONS = 8,
    parameter  int unsigned MULT_LAT  = 1,
    localparam int unsigned CNT_W     = clog2_min1(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             res_ready,
`ifdef CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             ld_input,
    output logic             ld_weight,
    output logic             ld_nreg,
    output logic             count_up,
    output logic             res_valid,
    output logic [CNT_W-1:0] neuron_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [LAT_W-1:0] WAIT_INIT  = (MULT_LAT > 0) ? LAT_W'(MULT_LAT - 1) : '0;
    localparam state_e           AFTER_LOAD = (MULT_LAT > 0) ? S_WAIT : S_ACC;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N_NEURONS - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic             done_nxt;
    logic             tmr_load;
    logic [LAT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    lat_timer u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero)
    );

    // Next-state, index and wait-timer control
    always_comb begin
        state_nxt = state;
        idx_nxt   = neuron_idx;
        done_nxt  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                tmr_load  = 1'b1;
                tmr_val   = WAIT_INIT;
                state_nxt = AFTER_LOAD;
            end
            S_WAIT: begin
                if (tmr_zero) begin
                    state_nxt = S_ACC;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_ACC: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (res_valid && res_ready) begin
                    if (neuron_idx == LAST_IDX) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                        idx_nxt   = neuron_idx + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
`ifdef CTRL_ABORT_EN
        // Abort outranks every other transition, including the final handshake
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = '0;
            tmr_dec   = 1'b0;
        end
`endif
    end

    // Outputs are registered, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            neuron_idx <= '0;
            done       <= 1'b0;
            ld_input   <= 1'b0;
            ld_weight  <= 1'b0;
            ld_nreg    <= 1'b0;
            count_up   <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            neuron_idx <= idx_nxt;
            done       <= done_nxt;
            ld_input   <= (state_nxt == S_LOAD);
            ld_weight  <= (state_nxt == S_LOAD);
            ld_nreg    <= (state_nxt == S_ACC);
            count_up   <= (state_nxt == S_ACC);
            res_valid  <= (state_nxt == S_OUT);
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: four instances (N/LAT = 8/1, 8/0, 8/15, 1/1) checked
// every cycle against a phase-counting reference model, plus directed sequences.
module tb_layer_controller;
    import nn_ctrl_pkg::*;

`ifdef CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam int unsigned NS [4] = '{8, 8, 8, 1};
    localparam int unsigned LS [4] = '{1, 0, 15, 1};

    typedef struct packed {
        logic       busy;
        logic       ld_input;
        logic       ld_weight;
        logic       ld_nreg;
        logic       count_up;
        logic       res_valid;
        logic       done;
        logic [7:0] idx;
    } obs_t;

    // Model: position p inside a neuron (0 = operand load, lat+1 = accumulate,
    // lat+2 = result offered), neuron number and a one-cycle done flag.
    typedef struct {
        int n;
        int lat;
        bit active;
        int p;
        int idx;
        bit done;
    } model_t;

    typedef struct {
        bit start;
        bit rdy;
        bit busy;
        bit li;
        bit ln;
        bit rv;
        bit dn;
    } vec_t;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] start_v;
    logic [3:0] rdy_v;
    logic [3:0] abort_v;
    obs_t       obs [4];
    model_t     m [4];
    int         cyc;
    int         n_vec;
    int         n_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned CW = clog2_min1(NS[g]);
        logic [CW-1:0] idx;
        logic b, li, lw, ln, cu, rv, dn;

        layer_controller #(.N_NEURONS(NS[g]), .MULT_LAT(LS[g])) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .start      (start_v[g]),
            .res_ready  (rdy_v[g]),
`ifdef CTRL_ABORT_EN
            .abort      (abort_v[g]),
`endif
            .ld_input   (li),
            .ld_weight  (lw),
            .ld_nreg    (ln),
            .count_up   (cu),
            .res_valid  (rv),
            .neuron_idx (idx),
            .busy       (b),
            .done       (dn)
        );

        assign obs[g] = {b, li, lw, ln, cu, rv, dn, 8'(idx)};
    end

    function automatic model_t step(input model_t mi, input bit r, input bit s,
                                    input bit rd, input bit ab);
        model_t q = mi;
        q.done = 1'b0;
        if (!r) begin
            q.active = 1'b0;
            q.p      = 0;
            q.idx    = 0;
        end else if (!mi.active) begin
            if (s) begin
                q.active = 1'b1;
                q.p      = 0;
                q.idx    = 0;
            end
        end else if (ABORT_EN && ab) begin
            q.active = 1'b0;
            q.p      = 0;
            q.idx    = 0;
        end else if (mi.p < mi.lat + 2) begin
            q.p = mi.p + 1;
        end else if (rd) begin
            if (mi.idx == mi.n - 1) begin
                q.active = 1'b0;
                q.p      = 0;
                q.idx    = 0;
                q.done   = 1'b1;
            end else begin
                q.idx = mi.idx + 1;
                q.p   = 0;
            end
        end
        return q;
    endfunction

    function automatic obs_t expect_of(input model_t mi);
        obs_t e;
        e.busy      = mi.active;
        e.ld_input  = mi.active && (mi.p == 0);
        e.ld_weight = mi.active && (mi.p == 0);
        e.ld_nreg   = mi.active && (mi.p == mi.lat + 1);
        e.count_up  = mi.active && (mi.p == mi.lat + 1);
        e.res_valid = mi.active && (mi.p == mi.lat + 2);
        e.done      = mi.done;
        e.idx       = 8'(mi.idx);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // One clock: advance the model on the inputs the DUT is about to sample, then compare
    task automatic tick();
        obs_t e;
        for (int i = 0; i < 4; i++)
            m[i] = step(m[i], rst_v[i], start_v[i], rdy_v[i], abort_v[i]);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            e = expect_of(m[i]);
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL model[%0d] at cycle %0d: got %h, want %h", i, cyc, obs[i], e);
            end
        end
    endtask

    task automatic run_pass(input int i, input int sidx, input int slen);
        int load_cyc, done_cyc, last_li, n_hs, left, lat, n;
        bit stall_seen;
        n = m[i].n; lat = m[i].lat;
        last_li = -1; done_cyc = -1; n_hs = 0; left = 0; stall_seen = 1'b0;
        rdy_v[i] = 1'b1; start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        load_cyc = cyc;
        for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
            if (obs[i].ld_input) begin
                if (last_li >= 0 && slen == 0) chk("period", cyc - last_li, lat + 3);
                last_li = cyc;
            end
            if (obs[i].ld_nreg) chk("load_to_acc", cyc - last_li, lat + 1);
            if (obs[i].done) begin
                done_cyc = cyc;
            end else begin
                rdy_v[i] = 1'b1;
                if (!stall_seen && slen > 0 && obs[i].res_valid && int'(obs[i].idx) == sidx) begin
                    stall_seen = 1'b1;
                    left = slen;
                end
                if (left > 0) begin
                    if (left < slen) begin
                        chk("stall_valid", int'(obs[i].res_valid), 1);
                        chk("stall_idx", int'(obs[i].idx), sidx);
                        chk("stall_ld", int'(obs[i].ld_input | obs[i].ld_nreg), 0);
                    end
                    rdy_v[i] = 1'b0;
                    left--;
                end
                if (obs[i].res_valid && rdy_v[i]) begin
                    chk("hs_idx", int'(obs[i].idx), n_hs);
                    n_hs++;
                end
                tick();
            end
        end
        rdy_v[i] = 1'b1;
        chk("hs_count", n_hs, n);
        chk("pass_len", done_cyc - load_cyc, n * (lat + 3) + slen);
    endtask

    initial begin
        vec_t tbl [13];
        int   ndone;
        bit   found;

        cyc = 0; n_vec = 0; n_err = 0;
        for (int i = 0; i < 4; i++) m[i] = '{n: NS[i], lat: LS[i], active: 1'b0, p: 0, idx: 0, done: 1'b0};
        rst_v = '0; start_v = '0; rdy_v = '1; abort_v = '0;

        tick();
        tick();
        for (int i = 0; i < 4; i++) chk("reset_obs", int'(obs[i]), 0);
        rst_v = '1;

        // N=1, start held high: back-to-back passes, restart in the done cycle
        tbl[0]  = '{1, 1, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 1, 0, 1, 0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 1, 0, 0, 0};
        for (int v = 0; v < 13; v++) begin
            start_v[3] = tbl[v].start;
            rdy_v[3]   = tbl[v].rdy;
            tick();
            chk($sformatf("n1_vec%0d", v),
                int'({obs[3].busy, obs[3].ld_input, obs[3].ld_nreg, obs[3].res_valid, obs[3].done, obs[3].idx}),
                int'({tbl[v].busy, tbl[v].li, tbl[v].ln, tbl[v].rv, tbl[v].dn, 8'd0}));
        end
        start_v[3] = 1'b0; rdy_v[3] = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // Full passes at each latency, then back-pressure on neuron 3
        run_pass(0, -1, 0);
        run_pass(1, -1, 0);
        run_pass(2, -1, 0);
        run_pass(0, 3, 5);

        // Reset during the wait of neuron 4 abandons the pass silently
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (obs[0].busy && obs[0].idx == 8'd4 && !obs[0].ld_input && !obs[0].ld_nreg && !obs[0].res_valid)
                found = 1'b1;
            else
                tick();
        end
        chk("reach_wait4", int'(found), 1);
        rst_v[0] = 1'b0; tick(); rst_v[0] = 1'b1;
        chk("rst_mid_pass", int'(obs[0]), 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            ndone += int'(obs[0].done);
        end
        chk("no_done_after_rst", ndone, 0);
        run_pass(0, -1, 0);

`ifdef CTRL_ABORT_EN
        // Abort coinciding with the final handshake: back to idle without done
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (obs[0].res_valid && obs[0].idx == 8'd7) found = 1'b1;
            else tick();
        end
        chk("reach_out7", int'(found), 1);
        abort_v[0] = 1'b1; rdy_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
        chk("abort_busy", int'(obs[0].busy), 0);
        chk("abort_done", int'(obs[0].done), 0);
        chk("abort_idx", int'(obs[0].idx), 0);
        tick();
        chk("abort_done_next", int'(obs[0].done), 0);
`endif

        // Random traffic on all instances against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                rst_v[i]   = ($urandom_range(0, 199) != 0);
                start_v[i] = ($urandom_range(0, 7) == 0);
                rdy_v[i]   = ($urandom_range(0, 1) == 1);
                abort_v[i] = ($urandom_range(0, 63) == 0);
            end
            tick();
        end
        rst_v = '1; start_v = '0; rdy_v = '1; abort_v = '0;
        for (int k = 0; k < 4; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
